// File: rtl/image_gradient.sv
// Streaming 3x3 Sobel gradient-magnitude stage: raster grey pixels in, {mag,mag,mag} out.
// Two line buffers feed a sliding window; the whole pipeline freezes while the output is held.
module image_gradient #(
  parameter int unsigned IMG_W = 256,
  parameter int unsigned IMG_H = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        i_grey_busy,
  input  logic        i_grey_vld,
  input  logic [23:0] i_grey_data,
  input  logic        o_result_busy,
  output logic        o_result_vld,
  output logic [23:0] o_result_data
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);

  logic [XW-1:0]      x;
  logic [YW-1:0]      y;
  logic [7:0]         lb0 [IMG_W];
  logic [7:0]         lb1 [IMG_W];
  logic [7:0]         p   [3][3];
  logic               stall;
  logic               accept;
  logic [7:0]         pix;
  logic               s1_vld;
  logic               s1_border;
  logic               s2_vld;
  logic               s2_border;
  logic [11:0]        s2_sum;
  logic signed [11:0] gx;
  logic signed [11:0] gy;
  logic [11:0]        ax;
  logic [11:0]        ay;
  logic [11:0]        sum;
  logic [7:0]         mag;
  logic               unused_hi;

  assign unused_hi   = ^i_grey_data[23:8];
  assign pix         = i_grey_data[7:0];
  assign stall       = o_result_vld & o_result_busy;
  assign i_grey_busy = stall;
  assign accept      = i_grey_vld & ~stall;

  function automatic logic signed [11:0] ext(input logic [7:0] v);
    return signed'({4'b0000, v});
  endfunction

  // Line buffers and window are data-only; border flags mask their stale contents.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      lb1[x] <= lb0[x];
      lb0[x] <= pix;
      for (int unsigned r = 0; r < 3; r++) begin
        p[r][0] <= p[r][1];
        p[r][1] <= p[r][2];
      end
      p[0][2] <= lb1[x];
      p[1][2] <= lb0[x];
      p[2][2] <= pix;
    end
  end

  always_comb begin
    gx  = (ext(p[0][2]) + (ext(p[1][2]) <<< 1) + ext(p[2][2]))
        - (ext(p[0][0]) + (ext(p[1][0]) <<< 1) + ext(p[2][0]));
    gy  = (ext(p[2][0]) + (ext(p[2][1]) <<< 1) + ext(p[2][2]))
        - (ext(p[0][0]) + (ext(p[0][1]) <<< 1) + ext(p[0][2]));
    ax  = gx[11] ? 12'(-gx) : 12'(gx);
    ay  = gy[11] ? 12'(-gy) : 12'(gy);
    sum = ax + ay;
    mag = s2_border ? 8'h00 : ((s2_sum > 12'd255) ? 8'hFF : s2_sum[7:0]);
  end

  // Window update, |Gx|+|Gy| register, then saturated output register: two edges after acceptance.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      x             <= '0;
      y             <= '0;
      s1_vld        <= 1'b0;
      s1_border     <= 1'b0;
      s2_vld        <= 1'b0;
      s2_border     <= 1'b0;
      s2_sum        <= '0;
      o_result_vld  <= 1'b0;
      o_result_data <= '0;
    end else if (!stall) begin
      s1_vld <= accept;
      if (accept) begin
        s1_border <= (x < XW'(2)) || (y < YW'(2));
        if (x == XW'(IMG_W - 1)) begin
          x <= '0;
          y <= (y == YW'(IMG_H - 1)) ? '0 : y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
      s2_vld       <= s1_vld;
      s2_border    <= s1_border;
      s2_sum       <= sum;
      o_result_vld <= s2_vld;
      if (s2_vld) o_result_data <= {3{mag}};
    end
  end

endmodule

// File: tb/tb_image_gradient.sv
// Self-checking bench for image_gradient on a 4x4 image: directed pattern table,
// latency/reset/backpressure sequences, and randomized frames against an arithmetic Sobel model.
module tb_image_gradient;
  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_grey_busy;
  logic        i_grey_vld = 1'b0;
  logic [23:0] i_grey_data = '0;
  logic        o_result_busy = 1'b0;
  logic        o_result_vld;
  logic [23:0] o_result_data;

  int          errors = 0;
  int          checks = 0;
  logic [23:0] got [$];
  bit          rand_busy = 1'b0;
  bit          rand_gaps = 1'b0;

  typedef struct {
    int         kind;      // 0 hramp, 1 vramp, 2 step, 3 flat
    logic [7:0] interior;  // expected magnitude at x>=2,y>=2
  } vec_t;
  vec_t tbl [4];

  image_gradient #(.IMG_W(W), .IMG_H(H)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_grey_busy(i_grey_busy),
    .i_grey_vld(i_grey_vld), .i_grey_data(i_grey_data),
    .o_result_busy(o_result_busy), .o_result_vld(o_result_vld),
    .o_result_data(o_result_data)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // An output transfer happens at the next rising edge when vld & !busy at the falling edge.
  always @(negedge i_clk)
    if (i_rst && o_result_vld && !o_result_busy) got.push_back(o_result_data);

  always @(posedge i_clk) begin
    #1;
    if (rand_busy) o_result_busy = ($urandom_range(0, 3) == 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int kind, input int x, input int y);
    case (kind)
      0:       return 8'(10 * x);
      1:       return 8'(10 * y);
      2:       return (x >= 2) ? 8'd200 : 8'd0;
      default: return 8'd123;
    endcase
  endfunction

  function automatic int px(input int img[N], input int x, input int y);
    return img[y * W + x];
  endfunction

  function automatic int ref_mag(input int img[N], input int x, input int y);
    int gx, gy, s;
    if (x < 2 || y < 2) return 0;
    gx = (px(img, x, y-2) + 2*px(img, x, y-1) + px(img, x, y))
       - (px(img, x-2, y-2) + 2*px(img, x-2, y-1) + px(img, x-2, y));
    gy = (px(img, x-2, y) + 2*px(img, x-1, y) + px(img, x, y))
       - (px(img, x-2, y-2) + 2*px(img, x-1, y-2) + px(img, x, y-2));
    s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (s > 255) ? 255 : s;
  endfunction

  task automatic send(input logic [7:0] p);
    bit ok = 1'b0;
    i_grey_vld  = 1'b1;
    i_grey_data = {16'($urandom), p};
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge i_clk);
      ok = !i_grey_busy;
      @(posedge i_clk);
      #1;
    end
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic send_frame(input int img[N]);
    for (int k = 0; k < N; k++) begin
      send(8'(img[k]));
      if (rand_gaps && $urandom_range(0, 2) == 0) begin
        i_grey_vld = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge i_clk); #1; end
      end
    end
    i_grey_vld = 1'b0;
  endtask

  task automatic wait_drain(input int n);
    for (int c = 0; c < 400 && got.size() < n; c++) @(posedge i_clk);
    repeat (4) @(posedge i_clk);
    #1;
    check("drain_count", got.size(), n);
  endtask

  function automatic logic [23:0] pop_got();
    if (got.size() == 0) return 24'hxxxxxx;
    return got.pop_front();
  endfunction

  task automatic compare_table(input string name, input vec_t v);
    for (int k = 0; k < N; k++) begin
      int x = k % W, y = k / W;
      logic [7:0] e = (x >= 2 && y >= 2) ? v.interior : 8'h00;
      check(name, {8'h0, pop_got()}, {8'h0, {3{e}}});
    end
  endtask

  task automatic compare_model(input string name, input int img[N]);
    for (int k = 0; k < N; k++) begin
      logic [7:0] e = 8'(ref_mag(img, k % W, k / W));
      check(name, {8'h0, pop_got()}, {8'h0, {3{e}}});
    end
  endtask

  task automatic make_img(input int kind, output int img[N]);
    for (int k = 0; k < N; k++) img[k] = int'(pat(kind, k % W, k / W));
  endtask

  task automatic do_reset();
    i_grey_vld = 1'b0;
    i_rst = 1'b0;
    repeat (2) begin @(posedge i_clk); #1; end
    got.delete();
    i_rst = 1'b1;
  endtask

  initial begin
    int img [N];
    int rimg [N];
    logic [23:0] held;

    tbl[0] = '{kind: 0, interior: 8'h50};
    tbl[1] = '{kind: 1, interior: 8'h50};
    tbl[2] = '{kind: 2, interior: 8'hFF};
    tbl[3] = '{kind: 3, interior: 8'h00};

    // Reset held with input valid and downstream busy: nothing moves.
    i_grey_vld = 1'b1;
    i_grey_data = 24'h0000AA;
    o_result_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      check("rst_vld", o_result_vld, 0);
      check("rst_data", o_result_data, 0);
      check("rst_busy", i_grey_busy, 0);
    end
    @(posedge i_clk); #1;
    i_grey_vld = 1'b0;
    o_result_busy = 1'b0;
    i_rst = 1'b1;
    repeat (4) begin @(posedge i_clk); #1; end
    check("rst_no_xfer", got.size(), 0);

    // Latency: accept at edge N, valid visible only after edge N+2.
    i_grey_vld = 1'b1;
    i_grey_data = 24'h000033;
    @(posedge i_clk); #1;
    i_grey_vld = 1'b0;
    @(posedge i_clk); #1;
    check("lat_n1_vld", o_result_vld, 0);
    @(posedge i_clk); #1;
    check("lat_n2_vld", o_result_vld, 1);
    check("lat_n2_data", o_result_data, 0);
    @(posedge i_clk); #1;
    check("lat_drain_vld", o_result_vld, 0);
    do_reset();

    // Directed pattern table, back-to-back, no backpressure.
    foreach (tbl[t]) begin
      make_img(tbl[t].kind, img);
      send_frame(img);
      wait_drain(N);
      compare_table($sformatf("table%0d", t), tbl[t]);
    end

    // Backpressure: 5 stalled cycles mid-frame.
    do_reset();
    make_img(0, img);
    fork
      send_frame(img);
      begin
        repeat (8) @(posedge i_clk);
        #1;
        o_result_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
          @(negedge i_clk);
          if (i == 0) held = o_result_data;
          else check("stall_data", o_result_data, held);
          check("stall_vld", o_result_vld, 1);
          check("stall_in_busy", i_grey_busy, 1);
        end
        @(posedge i_clk); #1;
        o_result_busy = 1'b0;
      end
    join
    wait_drain(N);
    compare_table("stall_frame", tbl[0]);

    // Two random frames back-to-back, then reset in the third frame.
    for (int k = 0; k < N; k++) rimg[k] = $urandom_range(0, 255);
    for (int k = 0; k < N; k++) send(8'(rimg[k]));
    for (int k = 0; k < N; k++) send(8'(rimg[k]));
    i_grey_vld = 1'b0;
    wait_drain(2 * N);
    compare_model("frame1", rimg);
    compare_model("frame2", rimg);
    for (int k = 0; k < 6; k++) send(8'(rimg[k]));
    i_rst = 1'b0;
    @(negedge i_clk);
    check("midrst_vld", o_result_vld, 0);
    check("midrst_data", o_result_data, 0);
    @(posedge i_clk); #1;
    i_grey_vld = 1'b0;
    got.delete();
    i_rst = 1'b1;
    make_img(1, img);
    send_frame(img);
    wait_drain(N);
    compare_table("after_midrst", tbl[1]);

    // Randomized frames with input gaps and random downstream busy.
    rand_busy = 1'b1;
    rand_gaps = 1'b1;
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < N; k++)
        rimg[k] = ($urandom_range(0, 3) == 0) ? 255 * $urandom_range(0, 1) : $urandom_range(0, 255);
      send_frame(rimg);
      rand_busy = 1'b0;
      @(posedge i_clk); #1;
      o_result_busy = 1'b0;
      wait_drain(N);
      compare_model($sformatf("rand%0d", f), rimg);
      rand_busy = 1'b1;
    end
    rand_busy = 1'b0;
    @(posedge i_clk); #1;
    o_result_busy = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
